// File: rtl/tmux_lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons. One shared update
// datapath visits the neurons round-robin, one per enabled cycle.
module tmux_lif_array #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int WEIGHT     = 100,
  parameter int CHAIN      = 1,
  localparam int IW        = $clog2(N_NEURONS),
  localparam int RCW       = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_NEURONS*WIDTH-1:0] cur_in,
  input  logic [IW-1:0]              obs_idx,
  output logic [N_NEURONS-1:0]       spike,
  output logic [WIDTH-1:0]           obs_state,
  output logic [IW-1:0]              scan_idx,
  output logic                       frame_done
);

  localparam logic [IW-1:0]      LAST_IDX = IW'(N_NEURONS - 1);
  localparam logic [WIDTH+1:0]   SAT_MAX  = {2'b00, {WIDTH{1'b1}}};

  logic [WIDTH-1:0]     state_q [N_NEURONS];
  logic [RCW-1:0]       rc_q    [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q;
  logic [IW-1:0]        scan_q;
  logic [WIDTH-1:0]     obs_q;
  logic                 frame_done_q;

  logic [WIDTH-1:0]     cur_arr_s [N_NEURONS];
  logic [WIDTH-1:0]     st_s;
  logic [WIDTH+1:0]     v_s;
  logic [WIDTH-1:0]     v_sat_s;
  logic                 chain_hit_s;
  logic [WIDTH-1:0]     state_d;
  logic                 spike_d;
  logic [RCW-1:0]       rc_d;
  logic [IW-1:0]        scan_d;
  logic [WIDTH-1:0]     obs_d;

  // Shared update datapath for the neuron at scan_q.
  always_comb begin
    for (int i = 0; i < N_NEURONS; i++) begin
      cur_arr_s[i] = cur_in[i*WIDTH +: WIDTH];
    end
    st_s        = state_q[scan_q];
    chain_hit_s = 1'b0;
    if ((CHAIN != 0) && (scan_q != {IW{1'b0}})) begin
      chain_hit_s = spike_q[scan_q - IW'(1)];
    end else begin
      chain_hit_s = 1'b0;
    end
    // Leak never exceeds the state, so the subtraction stays non-negative.
    v_s = {2'b00, st_s} - {2'b00, (st_s >> LEAK_SHIFT)} + {2'b00, cur_arr_s[scan_q]}
        + (chain_hit_s ? (WIDTH+2)'(WEIGHT) : {(WIDTH+2){1'b0}});
    if (v_s > SAT_MAX) begin
      v_sat_s = {WIDTH{1'b1}};
    end else begin
      v_sat_s = v_s[WIDTH-1:0];
    end
    if (rc_q[scan_q] != {RCW{1'b0}}) begin
      state_d = {WIDTH{1'b0}};
      spike_d = 1'b0;
      rc_d    = rc_q[scan_q] - RCW'(1);
    end else if (v_sat_s >= WIDTH'(THRESH)) begin
      state_d = {WIDTH{1'b0}};
      spike_d = 1'b1;
      rc_d    = RCW'(REFRAC);
    end else begin
      state_d = v_sat_s;
      spike_d = 1'b0;
      rc_d    = {RCW{1'b0}};
    end
    if (scan_q == LAST_IDX) begin
      scan_d = {IW{1'b0}};
    end else begin
      scan_d = scan_q + IW'(1);
    end
    if (int'(obs_idx) < N_NEURONS) begin
      obs_d = state_q[obs_idx];
    end else begin
      obs_d = {WIDTH{1'b0}};
    end
  end

  // Register file, scan counter and registered observation outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= {WIDTH{1'b0}};
        rc_q[i]    <= {RCW{1'b0}};
      end
      spike_q      <= {N_NEURONS{1'b0}};
      scan_q       <= {IW{1'b0}};
      obs_q        <= {WIDTH{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      obs_q <= obs_d;
      if (en) begin
        state_q[scan_q] <= state_d;
        rc_q[scan_q]    <= rc_d;
        spike_q[scan_q] <= spike_d;
        scan_q          <= scan_d;
        frame_done_q    <= (scan_q == LAST_IDX);
      end else begin
        frame_done_q    <= 1'b0;
      end
    end
  end

  assign spike      = spike_q;
  assign obs_state  = obs_q;
  assign scan_idx   = scan_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tmux_lif_array.sv
// Scoreboard bench for tmux_lif_array with default parameters (N=4, CHAIN=1, REFRAC=2).
module tb_tmux_lif_array;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] cur_in;
  logic [1:0]  obs_idx;
  logic [3:0]  spike;
  logic [7:0]  obs_state;
  logic [1:0]  scan_idx;
  logic        frame_done;

  int n_cmp;
  int n_err;

  int q_scan[$];
  int q_fd[$];
  int q_obs[$];
  int q_spk[$];

  tmux_lif_array dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cur_in    (cur_in),
    .obs_idx   (obs_idx),
    .spike     (spike),
    .obs_state (obs_state),
    .scan_idx  (scan_idx),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en      = 1'b1;
    cur_in  = {8'd30, 8'd30, 8'd30, 8'd30};
    obs_idx = 2'd0;
    do_reset();
    n_cmp++;
    if (spike !== 4'd0 || obs_state !== 8'd0 || scan_idx !== 2'd0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: spike=%h obs=%0d scan=%0d fd=%b, required 0/0/0/0", spike, obs_state, scan_idx, frame_done);
    end
    step();
    n_cmp++;
    if (scan_idx !== 2'd1) begin
      n_err++;
      $display("FAIL reset_first_scan: scan=%0d, required 1", scan_idx);
    end
    step();
    n_cmp++;
    if (obs_state !== 8'd30) begin
      n_err++;
      $display("FAIL reset_first_update: obs=%0d, required 30", obs_state);
    end
  endtask

  task automatic test_integrate_leak();
    int exp_v[8];
    exp_v = '{100, 150, 175, 188, 194, 197, 199, 0};
    en = 1'b0;
    cur_in = {8'd0, 8'd0, 8'd0, 8'd100};
    obs_idx = 2'd0;
    do_reset();
    en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      q_obs.push_back(exp_v[f]);
      q_spk.push_back((f == 7) ? 1 : 0);
    end
    for (int f = 0; f < 8; f++) begin
      int eo;
      int es;
      for (int c = 0; c < 4; c++) step();
      eo = q_obs.pop_front();
      es = q_spk.pop_front();
      n_cmp++;
      if (int'(obs_state) !== eo || int'(spike[0]) !== es) begin
        n_err++;
        $display("FAIL integrate frame %0d: state=%0d spike0=%b, required state=%0d spike0=%0d", f, obs_state, spike[0], eo, es);
      end
    end
  endtask

  task automatic test_refractory_sat();
    en = 1'b0;
    cur_in = {8'd0, 8'd0, 8'd0, 8'd255};
    obs_idx = 2'd0;
    do_reset();
    en = 1'b1;
    for (int f = 0; f < 6; f++) q_spk.push_back((f % 3 == 0) ? 1 : 0);
    for (int f = 0; f < 6; f++) begin
      int es;
      for (int c = 0; c < 4; c++) step();
      es = q_spk.pop_front();
      n_cmp++;
      if (int'(spike[0]) !== es || obs_state !== 8'd0) begin
        n_err++;
        $display("FAIL refractory frame %0d: spike0=%b state=%0d, required spike0=%0d state=0", f, spike[0], obs_state, es);
      end
    end
  endtask

  task automatic test_chain();
    int exp_v[4];
    exp_v = '{100, 50, 25, 113};
    en = 1'b0;
    cur_in = {8'd0, 8'd0, 8'd0, 8'd255};
    obs_idx = 2'd1;
    do_reset();
    en = 1'b1;
    for (int f = 0; f < 4; f++) q_obs.push_back(exp_v[f]);
    for (int f = 0; f < 4; f++) begin
      int eo;
      for (int c = 0; c < 4; c++) step();
      eo = q_obs.pop_front();
      n_cmp++;
      if (int'(obs_state) !== eo || spike[3:1] !== 3'b000) begin
        n_err++;
        $display("FAIL chain frame %0d: n1 state=%0d spike[3:1]=%b, required %0d / 000", f, obs_state, spike[3:1], eo);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [7:0] en_pat;
    int sc[8];
    int fd[8];
    int ob[8];
    en_pat = 8'b1110_0011;
    sc = '{1, 2, 2, 2, 2, 3, 0, 1};
    fd = '{0, 0, 0, 0, 0, 0, 1, 0};
    ob = '{0, 0, 10, 10, 10, 10, 10, 10};
    en = 1'b0;
    cur_in = {8'd10, 8'd10, 8'd10, 8'd10};
    obs_idx = 2'd1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      q_scan.push_back(sc[c]);
      q_fd.push_back(fd[c]);
      q_obs.push_back(ob[c]);
    end
    for (int c = 0; c < 8; c++) begin
      int es;
      int ef;
      int eo;
      en = en_pat[c];
      cur_in = en_pat[c] ? {8'd10, 8'd10, 8'd10, 8'd10} : {8'd99, 8'd99, 8'd99, 8'd99};
      step();
      es = q_scan.pop_front();
      ef = q_fd.pop_front();
      eo = q_obs.pop_front();
      n_cmp++;
      if (int'(scan_idx) !== es || int'(frame_done) !== ef || int'(obs_state) !== eo || spike !== 4'd0) begin
        n_err++;
        $display("FAIL gating cycle %0d: scan=%0d fd=%b obs=%0d spike=%h, required scan=%0d fd=%0d obs=%0d spike=0",
                 c, scan_idx, frame_done, obs_state, spike, es, ef, eo);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int fd_seen;
    en = 1'b0;
    cur_in = {8'd10, 8'd10, 8'd10, 8'd10};
    obs_idx = 2'd0;
    do_reset();
    en = 1'b1;
    step();
    step();
    n_cmp++;
    if (scan_idx !== 2'd2) begin
      n_err++;
      $display("FAIL midreset_pre: scan=%0d, required 2", scan_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    en = 1'b0;
    fd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      obs_idx = 2'(i);
      step();
      if (frame_done) fd_seen++;
      n_cmp++;
      if (obs_state !== 8'd0 || scan_idx !== 2'd0) begin
        n_err++;
        $display("FAIL midreset_state n%0d: obs=%0d scan=%0d, required 0/0", i, obs_state, scan_idx);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (frame_done) fd_seen++;
    end
    n_cmp++;
    if (fd_seen !== 0 || scan_idx !== 2'd3) begin
      n_err++;
      $display("FAIL midreset_nofd: fd_count=%0d scan=%0d, required 0/3", fd_seen, scan_idx);
    end
    step();
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_fd: fd=%b, required 1", frame_done);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    en      = 1'b0;
    cur_in  = 32'd0;
    obs_idx = 2'd0;
    test_reset();
    test_integrate_leak();
    test_refractory_sat();
    test_chain();
    test_enable_gating();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
